// File: rtl/fp_issue_queue.sv
// In-order issue buffer between FP operand preprocessing and the FP execution units.
// The head entry issues to its one-hot target unit once that unit is ready.
module fp_issue_queue #(
  parameter int NUM_UNITS = 5,
  parameter int DEPTH     = 4,
  parameter int ID_W      = 3,
  parameter int PAYLOAD_W = 64,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_UNITS-1:0] in_unit,
  input  logic [ID_W-1:0]      in_id,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [NUM_UNITS-1:0] unit_ready,
  output logic [NUM_UNITS-1:0] issue_new_request,
  output logic [ID_W-1:0]      issue_id,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_UNITS-1:0] unit_mem    [DEPTH];
  logic [ID_W-1:0]      id_mem      [DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

  logic [PTR_W-1:0]     head, tail, head_next, tail_next;
  logic [CNT_W-1:0]     count_next;
  logic [NUM_UNITS-1:0] head_unit;
  logic                 advance, push, pop;

  assign head_unit = unit_mem[head];

  // An all-zero target is a dropped entry: it leaves the head without a pulse.
  assign advance = (count != '0) && !flush &&
                   ((head_unit == '0) || ((unit_ready & head_unit) != '0));

  assign issue_new_request = head_unit & {NUM_UNITS{advance}};
  assign issue_id          = id_mem[head];
  assign issue_payload     = payload_mem[head];

  assign in_ready = !flush && ((count < CNT_W'(DEPTH)) || advance);
  assign push     = in_valid && in_ready;
  assign pop      = advance;

  assign head_next = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
  assign tail_next = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail_next;
      if (pop)  head <= head_next;
      count <= count_next;
    end
  end

  // Entry storage is left unreset; it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      unit_mem[tail]    <= in_unit;
      id_mem[tail]      <= in_id;
      payload_mem[tail] <= in_payload;
    end
  end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed self-checking bench for fp_issue_queue (DEPTH=4 instance plus a DEPTH=3 wrap run).
module tb_fp_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_unit, unit_ready, issue_new_request;
  logic [2:0]  in_id, issue_id, count;
  logic [63:0] in_payload, issue_payload;

  logic        d3_flush, d3_in_valid, d3_in_ready;
  logic [4:0]  d3_in_unit, d3_unit_ready, d3_issue;
  logic [2:0]  d3_in_id, d3_issue_id;
  logic [63:0] d3_in_payload, d3_issue_payload;
  logic [1:0]  d3_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_issue_queue #(.NUM_UNITS(5), .DEPTH(4), .ID_W(3), .PAYLOAD_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_id(in_id), .in_payload(in_payload), .unit_ready(unit_ready),
    .issue_new_request(issue_new_request), .issue_id(issue_id),
    .issue_payload(issue_payload), .count(count));

  fp_issue_queue #(.NUM_UNITS(5), .DEPTH(3), .ID_W(3), .PAYLOAD_W(64)) dut3 (
    .clk(clk), .rst(rst), .flush(d3_flush), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_unit(d3_in_unit), .in_id(d3_in_id), .in_payload(d3_in_payload),
    .unit_ready(d3_unit_ready), .issue_new_request(d3_issue), .issue_id(d3_issue_id),
    .issue_payload(d3_issue_payload), .count(d3_count));

  function automatic logic [4:0] unit_of(input logic [2:0] id);
    return 5'b00001 << (id % 5);
  endfunction

  function automatic logic [63:0] pl_of(input logic [2:0] id);
    return 64'hA5A5_0000_0000_0000 | 64'(id) * 64'h0000_0101_0101_0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] id, input logic [4:0] u);
    in_valid = v; in_id = id; in_unit = u; in_payload = pl_of(id);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; unit_ready = 5'b11111; drive(1'b0, 3'd0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL reset_issue got %b exp 00000", issue_new_request); end
    tick();
  endtask

  task automatic test_single_issue();
    drive(1'b1, 3'd1, 5'b00100);
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 00000", issue_new_request); end
    tick();
    drive(1'b0, 3'd0, 5'd0);
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b00100) begin errors++; $display("FAIL single_issue got %b exp 00100", issue_new_request); end
    checks++; if (issue_id !== 3'd1) begin errors++; $display("FAIL single_id got %0d exp 1", issue_id); end
    checks++; if (issue_payload !== pl_of(3'd1)) begin errors++; $display("FAIL single_payload got %h exp %h", issue_payload, pl_of(3'd1)); end
    tick();
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", count); end
    tick();
  endtask

  task automatic test_full_backpressure();
    unit_ready = 5'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), unit_of(3'(i)));
      tick();
    end
    drive(1'b1, 3'd4, unit_of(3'd4));
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tick();
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold_count got %0d exp 4", count); end
    tick();
    unit_ready = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (issue_new_request !== unit_of(3'(k))) begin errors++; $display("FAIL drain_issue k=%0d got %b exp %b", k, issue_new_request, unit_of(3'(k))); end
      checks++; if (issue_id !== 3'(k)) begin errors++; $display("FAIL drain_id k=%0d got %0d exp %0d", k, issue_id, k); end
      checks++; if (issue_payload !== pl_of(3'(k))) begin errors++; $display("FAIL drain_payload k=%0d got %h exp %h", k, issue_payload, pl_of(3'(k))); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready k=%0d got %b exp 1", k, in_ready); end
      tick();
      if (k == 0) drive(1'b0, 3'd0, 5'd0);
    end
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
    tick();
  endtask

  task automatic test_head_blocking();
    unit_ready = 5'b0;
    drive(1'b1, 3'd2, 5'b00001); tick();
    drive(1'b1, 3'd3, 5'b00010); tick();
    drive(1'b0, 3'd0, 5'd0);
    unit_ready = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL block_issue k=%0d got %b exp 00000", k, issue_new_request); end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL block_count k=%0d got %0d exp 2", k, count); end
      tick();
    end
    unit_ready = 5'b00001;
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b00001) begin errors++; $display("FAIL block_release got %b exp 00001", issue_new_request); end
    checks++; if (issue_id !== 3'd2) begin errors++; $display("FAIL block_release_id got %0d exp 2", issue_id); end
    tick();
    unit_ready = 5'b11111;
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b00010) begin errors++; $display("FAIL block_second got %b exp 00010", issue_new_request); end
    checks++; if (issue_id !== 3'd3) begin errors++; $display("FAIL block_second_id got %0d exp 3", issue_id); end
    tick();
  endtask

  task automatic test_drop();
    unit_ready = 5'b11111;
    drive(1'b1, 3'd5, 5'b00000); tick();
    drive(1'b1, 3'd7, 5'b01000);
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL drop_silent got %b exp 00000", issue_new_request); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 3'd0, 5'd0);
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b01000) begin errors++; $display("FAIL drop_next got %b exp 01000", issue_new_request); end
    checks++; if (issue_id !== 3'd7) begin errors++; $display("FAIL drop_next_id got %0d exp 7", issue_id); end
    tick();
  endtask

  task automatic test_flush();
    unit_ready = 5'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'(i), unit_of(3'(i)));
      tick();
    end
    drive(1'b1, 3'd4, unit_of(3'd4));
    unit_ready = 5'b11111;
    flush = 1'b1;
    @(negedge clk);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL flush_issue got %b exp 00000", issue_new_request); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 5'd0);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (issue_new_request !== 5'b0) begin errors++; $display("FAIL flush_after_issue got %b exp 00000", issue_new_request); end
    tick();
    drive(1'b1, 3'd6, 5'b10000); tick();
    drive(1'b0, 3'd0, 5'd0);
    @(negedge clk);
    checks++; if (issue_new_request !== 5'b10000) begin errors++; $display("FAIL flush_recover got %b exp 10000", issue_new_request); end
    checks++; if (issue_id !== 3'd6) begin errors++; $display("FAIL flush_recover_id got %0d exp 6", issue_id); end
    tick();
  endtask

  task automatic test_depth3_wrap();
    logic [2:0] mq[$];
    logic [2:0] next_id;
    logic       exp_adv, exp_ir;
    logic [4:0] exp_issue;
    next_id = 3'd0;
    for (int c = 0; c < 40; c++) begin
      d3_in_valid   = ($urandom_range(0, 3) != 0);
      d3_in_id      = next_id;
      d3_in_unit    = unit_of(next_id);
      d3_in_payload = pl_of(next_id);
      d3_unit_ready = 5'($urandom_range(0, 31));
      @(negedge clk);
      exp_adv   = (mq.size() != 0) && ((d3_unit_ready & unit_of(mq[0])) != 5'b0);
      exp_ir    = (mq.size() < 3) || exp_adv;
      exp_issue = exp_adv ? unit_of(mq[0]) : 5'b0;
      checks++; if (d3_count !== 2'(mq.size())) begin errors++; $display("FAIL d3_count c=%0d got %0d exp %0d", c, d3_count, mq.size()); end
      checks++; if (d3_in_ready !== exp_ir) begin errors++; $display("FAIL d3_in_ready c=%0d got %b exp %b", c, d3_in_ready, exp_ir); end
      checks++; if (d3_issue !== exp_issue) begin errors++; $display("FAIL d3_issue c=%0d got %b exp %b", c, d3_issue, exp_issue); end
      if (exp_adv) begin
        checks++; if (d3_issue_id !== mq[0]) begin errors++; $display("FAIL d3_order c=%0d got %0d exp %0d", c, d3_issue_id, mq[0]); end
        void'(mq.pop_front());
      end
      if (d3_in_valid && exp_ir) begin
        mq.push_back(next_id);
        next_id = next_id + 3'd1;
      end
      tick();
    end
    d3_in_valid = 1'b0;
  endtask

  initial begin
    d3_flush = 1'b0; d3_in_valid = 1'b0; d3_in_id = 3'd0; d3_in_unit = 5'd0;
    d3_in_payload = 64'd0; d3_unit_ready = 5'd0;
    test_reset();
    test_single_issue();
    test_full_backpressure();
    test_head_blocking();
    test_drop();
    test_flush();
    test_depth3_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
